// File: rtl/convolution_controller.sv
// convolution_controller: frame sequencer for the KxK convolution pipeline; tags each pipeline slot
// with window-valid/last and exposes a valid/ready result stream aligned with output_pixel.
module convolution_controller #(
    parameter int C_KERNEL_DIMENSION = 3,
    parameter int C_PIPE_LATENCY     = 6,
    parameter int C_DIM_WIDTH        = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [C_DIM_WIDTH-1:0] img_width,
    input  logic [C_DIM_WIDTH-1:0] img_height,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   lb_shift,
    output logic                   conv_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [C_DIM_WIDTH-1:0] K   = C_DIM_WIDTH'(C_KERNEL_DIMENSION);
    localparam logic [C_DIM_WIDTH-1:0] KM1 = C_DIM_WIDTH'(C_KERNEL_DIMENSION - 1);
    localparam logic [C_DIM_WIDTH-1:0] ONE = C_DIM_WIDTH'(1);
    state_t                   state;
    logic [C_DIM_WIDTH-1:0]   width_m1, height_m1, row, col;
    logic [C_PIPE_LATENCY-1:0] vld_sr, last_sr;
    logic                     at_eol, at_end, win;
    assign conv_en   = ~(out_valid & ~out_ready);
    assign in_ready  = (state == RUN) & conv_en;
    assign lb_shift  = in_valid & in_ready;
    assign at_eol    = col == width_m1;
    assign at_end    = at_eol & (row == height_m1);
    assign win       = (row >= KM1) & (col >= KM1);
    assign out_valid = vld_sr[C_PIPE_LATENCY-1];
    assign out_last  = last_sr[C_PIPE_LATENCY-1] & vld_sr[C_PIPE_LATENCY-1];
    assign busy      = (state == RUN) | (state == DRAIN);
    assign done      = state == DONE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            width_m1  <= '0;
            height_m1 <= '0;
            row       <= '0;
            col       <= '0;
            vld_sr    <= '0;
            last_sr   <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= (state == IDLE) & start & ((img_width < K) | (img_height < K));
            // a cycle without an accept pushes a bubble; a stall freezes every tag
            if (conv_en) begin
                vld_sr  <= (vld_sr << 1) | C_PIPE_LATENCY'(lb_shift & win);
                last_sr <= (last_sr << 1) | C_PIPE_LATENCY'(lb_shift & at_end);
            end
            if (lb_shift) begin
                col <= at_eol ? '0 : col + ONE;
                row <= at_eol ? row + ONE : row;
            end
            case (state)
                IDLE:
                    if (start & (img_width >= K) & (img_height >= K)) begin
                        width_m1  <= img_width - ONE;
                        height_m1 <= img_height - ONE;
                        row       <= '0;
                        col       <= '0;
                        state     <= RUN;
                    end
                RUN:     state <= (lb_shift & at_end) ? DRAIN : RUN;
                DRAIN:   state <= (out_valid & out_last & out_ready) ? DONE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_convolution_controller.sv
// tb_convolution_controller: table-driven frame scenarios plus hand-written reset/config sequences.
module tb_convolution_controller;
    localparam int DW = 11;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [DW-1:0] img_width = '0, img_height = '0;
    logic in_ready, lb_shift, conv_en, out_valid, out_last, busy, done, cfg_err;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    convolution_controller #(.C_KERNEL_DIMENSION(3), .C_PIPE_LATENCY(6), .C_DIM_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
        .in_valid(in_valid), .in_ready(in_ready), .lb_shift(lb_shift), .conv_en(conv_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .done(done), .cfg_err(cfg_err)
    );

    typedef struct packed {
        int w; int h; int toggle; int stall_from; int stall_len; int mid_start;
        int e_shift; int e_out; int e_first; int e_last; int e_done;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"}, int'(in_ready), 0);
        check({tag, " lb_shift"}, int'(lb_shift), 0);
        check({tag, " conv_en"}, int'(conv_en), 1);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " out_last"}, int'(out_last), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " cfg_err"}, int'(cfg_err), 0);
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        int n_shift = 0, n_out = 0, n_last = 0, first = -1, last = -1, dn = -1;
        int stalls = 0, viol = 0, busy_at_done = -1;
        logic pv = 1'b0, pr = 1'b1;
        string tag = $sformatf("frame%0d", idx);
        img_width  = DW'(v.w);
        img_height = DW'(v.h);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 80 && dn < 0; c++) begin
            if (c > 0) @(negedge clk);
            in_valid  = v.toggle != 0 ? (c % 2 == 0) : 1'b1;
            out_ready = !(c >= v.stall_from && c < v.stall_from + v.stall_len);
            start     = (c == v.mid_start);
            if (c == v.mid_start) begin
                img_width  = DW'(5);
                img_height = DW'(3);
            end
            #1;
            if (pv && !pr && !out_valid) viol++;
            if (!conv_en && in_ready) viol++;
            if (lb_shift) n_shift++;
            if (!conv_en) stalls++;
            if (out_valid && first < 0) first = c;
            if (out_valid && out_ready) n_out++;
            if (out_valid && out_ready && out_last) begin
                n_last++;
                last = c;
            end
            if (done) begin
                dn = c;
                busy_at_done = int'(busy);
            end
            pv = out_valid;
            pr = out_ready;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({tag, " shifts"}, n_shift, v.e_shift);
        check({tag, " outputs"}, n_out, v.e_out);
        check({tag, " first_valid_cycle"}, first, v.e_first);
        check({tag, " last_cycle"}, last, v.e_last);
        check({tag, " last_count"}, n_last, 1);
        check({tag, " done_cycle"}, dn, v.e_done);
        check({tag, " busy_at_done"}, busy_at_done, 0);
        check({tag, " stall_cycles"}, stalls, v.stall_len);
        check({tag, " hold_violations"}, viol, 0);
        @(negedge clk);
        #1;
        check({tag, " done_pulse_width"}, int'(done), 0);
    endtask

    initial begin
        //            w  h  tog sfrom slen mid  shift out first last done
        vecs[0] = '{4, 4, 0, 100, 0, -1, 16, 4, 16, 21, 22};
        vecs[1] = '{4, 4, 0, 16,  3, -1, 16, 4, 16, 24, 25};
        vecs[2] = '{3, 3, 1, 100, 0, -1, 9,  1, 22, 22, 23};
        vecs[3] = '{5, 3, 0, 100, 0, -1, 15, 3, 18, 20, 21};
        vecs[4] = '{3, 4, 0, 100, 0, -1, 12, 2, 14, 17, 18};
        vecs[5] = '{4, 4, 0, 100, 0, 5,  16, 4, 16, 21, 22};

        in_valid = 1'b1;
        start = 1'b1;
        img_width = DW'(4);
        img_height = DW'(4);
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

        // rejected dimensions
        for (int j = 0; j < 2; j++) begin
            int shifts = 0;
            @(negedge clk);
            img_width  = DW'(j == 0 ? 2 : 4);
            img_height = DW'(j == 0 ? 4 : 2);
            start = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("cfg%0d cfg_err", j), int'(cfg_err), 1);
            check($sformatf("cfg%0d busy", j), int'(busy), 0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                #1;
                if (lb_shift || busy || cfg_err) shifts++;
            end
            check($sformatf("cfg%0d idle_activity", j), shifts, 0);
            in_valid = 1'b0;
        end

        // reset in the middle of a frame
        begin
            int act = 0;
            img_width = DW'(4);
            img_height = DW'(4);
            @(negedge clk) start = 1'b1;
            @(negedge clk) begin
                start = 1'b0;
                in_valid = 1'b1;
            end
            repeat (7) @(negedge clk);
            #1;
            check("midrst busy_before", int'(busy), 1);
            rst = 1'b0;
            #1;
            check_reset_values("midrst");
            @(negedge clk) rst = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                #1;
                if (out_valid || lb_shift || busy || done) act++;
            end
            check("midrst post_release_activity", act, 0);
            in_valid = 1'b0;
            run_frame(6, vecs[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
